// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with one-cycle terminal-count pulse.
// Supports one-shot (IDLE after expiry) and periodic (auto-reload) operation.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            // A load always restarts; any expiry pending this cycle is dropped.
            count_d  = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? S_RUN : S_IDLE;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (en) begin
                        if (count_q == WIDTH'(1)) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = S_DONE;
                            end
                        end else if (count_q != '0) begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    count_d = '0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == S_RUN);
    assign tc    = tc_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Vector-table bench for down_counter_timer: each vector's expected outputs are
// queued when it is driven and checked just after the clock edge that applies it.
module tb_down_counter_timer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst, load, en, auto_reload;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             busy, tc;

    typedef struct {
        logic             rst;
        logic             load;
        logic [WIDTH-1:0] lv;
        logic             en;
        logic             ar;
        logic [WIDTH-1:0] exp_count;
        logic             exp_busy;
        logic             exp_tc;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             busy;
        logic             tc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    down_counter_timer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_val),
        .en         (en),
        .auto_reload(auto_reload),
        .count      (count),
        .busy       (busy),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic ld, input int lv,
                                input logic e, input logic ar,
                                input int ec, input logic eb, input logic et);
        vec_t v;
        v.rst = r; v.load = ld; v.lv = WIDTH'(lv); v.en = e; v.ar = ar;
        v.exp_count = WIDTH'(ec); v.exp_busy = eb; v.exp_tc = et;
        vecs.push_back(v);
    endfunction

    task automatic apply(input string name, input vec_t v);
        exp_t e, got;
        rst = v.rst; load = v.load; load_val = v.lv; en = v.en; auto_reload = v.ar;
        e.count = v.exp_count; e.busy = v.exp_busy; e.tc = v.exp_tc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        n_vec++;
        if (count !== got.count || busy !== got.busy || tc !== got.tc) begin
            n_err++;
            $display("FAIL %s vec %0d: count=%0d busy=%b tc=%b, want count=%0d busy=%b tc=%b",
                     name, n_vec, count, busy, tc, got.count, got.busy, got.tc);
        end
    endtask

    task automatic step(input string name, input logic r, input logic ld, input int lv,
                        input logic e, input logic ar,
                        input int ec, input logic eb, input logic et);
        vec_t v;
        v.rst = r; v.load = ld; v.lv = WIDTH'(lv); v.en = e; v.ar = ar;
        v.exp_count = WIDTH'(ec); v.exp_busy = eb; v.exp_tc = et;
        apply(name, v);
    endtask

    initial begin
        //   rst ld lv    en ar   cnt busy tc
        // reset with simultaneous load, then en ignored in IDLE
        add(1, 1, 4'hA, 0, 0,   0, 0, 0);
        add(1, 1, 4'hA, 0, 0,   0, 0, 0);
        add(0, 0, 0,    1, 0,   0, 0, 0);
        add(0, 0, 0,    1, 0,   0, 0, 0);
        // one-shot load 3 (load beats en)
        add(0, 1, 3,    1, 0,   3, 1, 0);
        add(0, 0, 0,    1, 0,   2, 1, 0);
        add(0, 0, 0,    1, 0,   1, 1, 0);
        add(0, 0, 0,    1, 0,   0, 0, 1);
        add(0, 0, 0,    1, 0,   0, 0, 0);
        add(0, 0, 0,    1, 0,   0, 0, 0);
        // periodic load 2 with en gaps
        add(0, 1, 2,    0, 1,   2, 1, 0);
        add(0, 0, 0,    1, 1,   1, 1, 0);
        add(0, 0, 0,    0, 1,   1, 1, 0);
        add(0, 0, 0,    1, 1,   2, 1, 1);
        add(0, 0, 0,    1, 1,   1, 1, 0);
        add(0, 0, 0,    1, 1,   2, 1, 1);
        add(0, 0, 0,    0, 1,   2, 1, 0);
        // load coinciding with the terminal decrement: no tc
        add(0, 1, 1,    0, 0,   1, 1, 0);
        add(0, 1, 2,    1, 0,   2, 1, 0);
        add(0, 0, 0,    1, 0,   1, 1, 0);
        add(0, 0, 0,    1, 0,   0, 0, 1);
        add(0, 0, 0,    0, 0,   0, 0, 0);
        // load 0 never starts
        add(0, 1, 0,    1, 0,   0, 0, 0);
        add(0, 0, 0,    1, 0,   0, 0, 0);
        add(0, 0, 0,    1, 1,   0, 0, 0);
        // period of 1
        add(0, 1, 1,    1, 1,   1, 1, 0);
        add(0, 0, 0,    1, 1,   1, 1, 1);
        add(0, 0, 0,    1, 1,   1, 1, 1);
        add(0, 0, 0,    0, 1,   1, 1, 0);
        // load 1 one-shot
        add(0, 1, 1,    0, 0,   1, 1, 0);
        add(0, 0, 0,    1, 0,   0, 0, 1);
        add(0, 0, 0,    0, 0,   0, 0, 0);
        // reset mid-run after 3 decrements
        add(0, 1, 6,    1, 0,   6, 1, 0);
        add(0, 0, 0,    1, 0,   5, 1, 0);
        add(0, 0, 0,    1, 0,   4, 1, 0);
        add(0, 0, 0,    1, 0,   3, 1, 0);
        add(1, 0, 0,    1, 0,   0, 0, 0);
        add(0, 0, 0,    1, 0,   0, 0, 0);
        add(0, 0, 0,    1, 0,   0, 0, 0);
        // reset coinciding with the terminal decrement suppresses tc
        add(0, 1, 2,    0, 0,   2, 1, 0);
        add(0, 0, 0,    1, 0,   1, 1, 0);
        add(1, 0, 0,    1, 0,   0, 0, 0);
        add(0, 0, 0,    1, 0,   0, 0, 0);

        foreach (vecs[i]) apply("table", vecs[i]);

        // restart: load 5, two decrements, reload 15, full countdown without wrap
        step("restart", 0, 1, 5,    0, 0,   5, 1, 0);
        step("restart", 0, 0, 0,    1, 0,   4, 1, 0);
        step("restart", 0, 0, 0,    1, 0,   3, 1, 0);
        step("restart", 0, 1, 4'hF, 1, 0,  15, 1, 0);
        for (int i = 14; i >= 1; i--)
            step("countdown", 0, 0, 0, 1, 0, i, 1, 0);
        step("expire", 0, 0, 0, 1, 0,   0, 0, 1);
        step("idle",   0, 0, 0, 1, 0,   0, 0, 0);
        step("idle",   0, 0, 0, 1, 0,   0, 0, 0);

        // load during the DONE cycle restarts the timer
        step("done_load", 0, 1, 1, 0, 0,   1, 1, 0);
        step("done_load", 0, 0, 0, 1, 0,   0, 0, 1);
        step("done_load", 0, 1, 3, 0, 0,   3, 1, 0);
        step("done_load", 0, 0, 0, 1, 0,   2, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
